bus_debug_bridge: RTL and testbench
===================================

BUS_DEBUG_BRIDGE -- requirements
Module: bus_debug_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning cycles to wait for ready_in before aborting a bus access.
REQ-002 SHALL have parameter CMD_READ, default 8'h01, meaning command byte for a bus read.
REQ-003 SHALL have parameter CMD_WRITE, default 8'h02, meaning command byte for a bus write.
REQ-004 clk  input  1  sole clock; all logic on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 rx_data_in  input  8  received command-stream byte.
REQ-007 rx_valid_in  input  1  one-cycle strobe qualifying rx_data_in; no backpressure.
REQ-008 tx_data_out  output  8  response byte.
REQ-009 tx_valid_out  output  1  response byte valid.
REQ-010 tx_ready_in  input  1  sink accepts byte when tx_valid_out && tx_ready_in.
REQ-011 address_out  output  32  bus address.
REQ-012 read_out / write_out  output  1 each  bus read / write request.
REQ-013 write_mask_out  output  4  byte-lane write enables.
REQ-014 write_value_out  output  32  write data.
REQ-015 read_value_in  input  32  read data, valid when ready_in.
REQ-016 ready_in / fault_in  input  1 each  access complete / access faulted.

Function
REQ-017 States SHALL be IDLE, ADDR, MASK, DATA, BUS, RESP.
REQ-018 IDLE: byte CMD_READ or CMD_WRITE latches op and goes to ADDR; any other byte loads status 8'hFF into RESP (1 byte).
REQ-019 ADDR SHALL collect 4 bytes little-endian into the address; then read goes to BUS, write goes to MASK.
REQ-020 MASK SHALL latch bits [3:0] of one byte (bits [7:4] ignored), then go to DATA.
REQ-021 DATA SHALL collect 4 bytes little-endian into write data, then go to BUS.
REQ-022 A 2-bit byte index SHALL reset to 0 on every entry to ADDR and DATA.
REQ-023 BUS SHALL assert read_out or write_out (never both) from the cycle after entry until the completion cycle inclusive, with address/mask/value held stable.
REQ-024 write_mask_out SHALL be 4'b0000 whenever write_out is low.
REQ-025 Completion SHALL be the first BUS cycle with ready_in or fault_in; the request SHALL deassert the next cycle.
REQ-026 Status SHALL be 8'h00 on ready_in without fault_in, 8'h01 on fault_in (priority over ready_in), 8'h02 on timeout.
REQ-027 Timeout SHALL fire when TIMEOUT_CYCLES request cycles elapse without completion; the request then deasserts.
REQ-028 RESP SHALL send the status byte, then for a successful read 4 read-data bytes little-endian (5 bytes total); otherwise status only.
REQ-029 tx_data_out/tx_valid_out SHALL hold until accepted; after the last acceptance, return to IDLE.
REQ-030 rx_valid_in strobes during BUS or RESP SHALL be discarded.
REQ-031 Minimum latency SHALL be 1 cycle from the last command byte to request assertion.

Reset
REQ-032 Reset SHALL force IDLE, read_out=0, write_out=0, tx_valid_out=0, write_mask_out=0, address_out=0, write_value_out=0, tx_data_out=0, and clear the counters.
REQ-033 Reset mid-BUS SHALL drop the request the next cycle with no response; a late ready_in SHALL be ignored.

Structure
REQ-034 Package bus_debug_bridge_pkg SHALL hold the state enum, status codes (OK 8'h00, FAULT 8'h01, TIMEOUT 8'h02, BADCMD 8'hFF), and the default command codes.
REQ-035 The block SHALL be one module with no sub-modules; the timeout counter is inline, width $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-036 Read: bytes 01,00,00,01,00 with ready_in and read_value_in=32'h0000_00A5 at the 3rd request cycle -> address_out=32'h0001_0000 with read_out high for 3 cycles; tx 00,A5,00,00,00.
REQ-037 Write: bytes 02,0C,00,01,00,03,EF,BE,AD,DE with ready_in at the 1st request cycle -> write_out high 1 cycle, address 32'h0001_000C, mask 4'b0011, value 32'hDEAD_BEEF; tx 00.
REQ-038 Fault: read of 32'h0400_0000 with ready_in=fault_in=1 -> tx 01 only.
REQ-039 Timeout: read with ready_in held low -> read_out high exactly 256 cycles; tx 02.
REQ-040 Bad command 7F -> tx FF, no bus activity. tx_ready_in held low 10 cycles during RESP -> byte held stable. Stray rx bytes in BUS -> ignored.
REQ-041 Reset asserted 2 cycles into BUS -> read_out low the next cycle; no tx; the next command decodes correctly.

Source files
------------

// File: rtl/bus_debug_bridge_pkg.sv
// Shared types and codes for the byte-stream bus debug bridge.
// Holds the FSM encoding, response status codes, default command bytes and a byte-insert helper.
package bus_debug_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_MASK,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } state_t;

  localparam logic [7:0] STATUS_OK      = 8'h00;
  localparam logic [7:0] STATUS_FAULT   = 8'h01;
  localparam logic [7:0] STATUS_TIMEOUT = 8'h02;
  localparam logic [7:0] STATUS_BADCMD  = 8'hFF;

  localparam logic [7:0] DEF_CMD_READ  = 8'h01;
  localparam logic [7:0] DEF_CMD_WRITE = 8'h02;

  // Captured command; addr/mask/wdata drive the bus directly while a request is up.
  typedef struct packed {
    logic        is_write;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  function automatic logic [31:0] put_byte(input logic [31:0] word,
                                           input logic [1:0]  idx,
                                           input logic [7:0]  b);
    logic [31:0] w;
    w = word;
    w[{idx, 3'b000} +: 8] = b;
    return w;
  endfunction

endpackage

// File: rtl/bus_debug_bridge.sv
// Command-byte to 32-bit bus bridge: request rises 1 cycle after the last command byte, status/data returned on tx.
// rx is never stalled (bytes during BUS/RESP are dropped); tx bytes hold until tx_ready_in.
module bus_debug_bridge
  import bus_debug_bridge_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 256,
  parameter logic [7:0] CMD_READ       = DEF_CMD_READ,
  parameter logic [7:0] CMD_WRITE      = DEF_CMD_WRITE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data_in,
  input  logic        rx_valid_in,
  output logic [7:0]  tx_data_out,
  output logic        tx_valid_out,
  input  logic        tx_ready_in,
  output logic [31:0] address_out,
  output logic        read_out,
  output logic        write_out,
  output logic [3:0]  write_mask_out,
  output logic [31:0] write_value_out,
  input  logic [31:0] read_value_in,
  input  logic        ready_in,
  input  logic        fault_in
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_nxt;
  cmd_t          cmd, cmd_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [31:0]   rdata, rdata_nxt;
  logic [2:0]    resp_idx, resp_idx_nxt;
  logic [2:0]    resp_last, resp_last_nxt;
  logic          req, req_nxt;
  logic          tx_vld, tx_vld_nxt;
  logic [7:0]    tx_dat, tx_dat_nxt;

  logic          start_bus;
  logic          finish;
  logic [7:0]    status;

  assign address_out     = cmd.addr;
  assign write_value_out = cmd.wdata;
  assign read_out        = req & ~cmd.is_write;
  assign write_out       = req &  cmd.is_write;
  assign write_mask_out  = write_out ? cmd.mask : 4'b0000;
  assign tx_data_out     = tx_dat;
  assign tx_valid_out    = tx_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cmd_nxt       = cmd;
    idx_nxt       = idx;
    timer_nxt     = timer;
    rdata_nxt     = rdata;
    resp_idx_nxt  = resp_idx;
    resp_last_nxt = resp_last;
    req_nxt       = req;
    tx_vld_nxt    = tx_vld;
    tx_dat_nxt    = tx_dat;
    start_bus     = 1'b0;
    finish        = 1'b0;
    status        = STATUS_OK;

    case (state)
      ST_IDLE: begin
        if (rx_valid_in) begin
          if (rx_data_in == CMD_READ || rx_data_in == CMD_WRITE) begin
            cmd_nxt.is_write = (rx_data_in == CMD_WRITE);
            idx_nxt          = 2'd0;
            state_nxt        = ST_ADDR;
          end else begin
            finish = 1'b1;
            status = STATUS_BADCMD;
          end
        end
      end
      ST_ADDR: begin
        if (rx_valid_in) begin
          cmd_nxt.addr = put_byte(cmd.addr, idx, rx_data_in);
          idx_nxt      = idx + 2'd1;
          if (idx == 2'd3) begin
            if (cmd.is_write) begin
              state_nxt = ST_MASK;
            end else begin
              start_bus = 1'b1;
            end
          end
        end
      end
      ST_MASK: begin
        if (rx_valid_in) begin
          cmd_nxt.mask = rx_data_in[3:0];
          idx_nxt      = 2'd0;
          state_nxt    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_valid_in) begin
          cmd_nxt.wdata = put_byte(cmd.wdata, idx, rx_data_in);
          idx_nxt       = idx + 2'd1;
          if (idx == 2'd3) begin
            start_bus = 1'b1;
          end
        end
      end
      ST_BUS: begin
        // Fault outranks ready; a completion on the last allowed cycle beats the timeout.
        if (fault_in) begin
          finish = 1'b1;
          status = STATUS_FAULT;
        end else if (ready_in) begin
          finish    = 1'b1;
          status    = STATUS_OK;
          rdata_nxt = read_value_in;
        end else if (timer == TMO_LAST) begin
          finish = 1'b1;
          status = STATUS_TIMEOUT;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      ST_RESP: begin
        if (tx_vld && tx_ready_in) begin
          if (resp_idx == resp_last) begin
            tx_vld_nxt = 1'b0;
            state_nxt  = ST_IDLE;
          end else begin
            tx_dat_nxt   = rdata[{resp_idx[1:0], 3'b000} +: 8];
            resp_idx_nxt = resp_idx + 3'd1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (start_bus) begin
      req_nxt   = 1'b1;
      timer_nxt = '0;
      state_nxt = ST_BUS;
    end

    if (finish) begin
      req_nxt       = 1'b0;
      tx_vld_nxt    = 1'b1;
      tx_dat_nxt    = status;
      resp_idx_nxt  = 3'd0;
      resp_last_nxt = (status == STATUS_OK && !cmd.is_write && state == ST_BUS) ? 3'd4 : 3'd0;
      state_nxt     = ST_RESP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd       <= '0;
      idx       <= '0;
      timer     <= '0;
      rdata     <= '0;
      resp_idx  <= '0;
      resp_last <= '0;
      req       <= 1'b0;
      tx_vld    <= 1'b0;
      tx_dat    <= '0;
    end else begin
      cmd       <= cmd_nxt;
      idx       <= idx_nxt;
      timer     <= timer_nxt;
      rdata     <= rdata_nxt;
      resp_idx  <= resp_idx_nxt;
      resp_last <= resp_last_nxt;
      req       <= req_nxt;
      tx_vld    <= tx_vld_nxt;
      tx_dat    <= tx_dat_nxt;
    end
  end

endmodule

// File: tb/tb_bus_debug_bridge.sv
// Directed and randomized transactions against a transaction-level model of the debug bridge.
module tb_bus_debug_bridge;

  localparam int TMO = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data_in;
  logic        rx_valid_in;
  logic [7:0]  tx_data_out;
  logic        tx_valid_out;
  logic        tx_ready_in;
  logic [31:0] address_out;
  logic        read_out;
  logic        write_out;
  logic [3:0]  write_mask_out;
  logic [31:0] write_value_out;
  logic [31:0] read_value_in;
  logic        ready_in;
  logic        fault_in;

  bus_debug_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .rx_data_in(rx_data_in), .rx_valid_in(rx_valid_in),
    .tx_data_out(tx_data_out), .tx_valid_out(tx_valid_out), .tx_ready_in(tx_ready_in),
    .address_out(address_out), .read_out(read_out), .write_out(write_out),
    .write_mask_out(write_mask_out), .write_value_out(write_value_out),
    .read_value_in(read_value_in), .ready_in(ready_in), .fault_in(fault_in)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0]  cmdq[$];
  logic [7:0]  txq[$];
  int          req_cycles;
  int          unstable;
  int          any_req;
  logic [31:0] seen_addr, seen_val;
  logic [3:0]  seen_mask;
  logic        seen_rd, seen_wr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd();
    foreach (cmdq[i]) begin
      @(negedge clk);
      rx_data_in  = cmdq[i];
      rx_valid_in = 1'b1;
    end
    @(negedge clk);
    rx_valid_in = 1'b0;
  endtask

  // Entered at the negedge of the first expected request cycle.
  task automatic run_bus(input int ready_at, input bit flt, input logic [31:0] rval, input bit stray);
    req_cycles = 0;
    unstable   = 0;
    seen_rd    = 1'b0;
    seen_wr    = 1'b0;
    for (int c = 1; c <= TMO + 20; c++) begin
      if (!(read_out || write_out)) break;
      req_cycles++;
      if (read_out && write_out) unstable++;
      if (c == 1) begin
        seen_addr = address_out; seen_val = write_value_out; seen_mask = write_mask_out;
        seen_rd   = read_out;    seen_wr  = write_out;
      end else if (address_out !== seen_addr || write_value_out !== seen_val ||
                   write_mask_out !== seen_mask) begin
        unstable++;
      end
      ready_in      = (c == ready_at);
      fault_in      = (c == ready_at) && flt;
      read_value_in = (c == ready_at) ? rval : $urandom;
      rx_valid_in   = stray && ($urandom_range(0, 1) == 1);
      rx_data_in    = 8'($urandom_range(0, 3));
      @(negedge clk);
    end
    ready_in    = 1'b0;
    fault_in    = 1'b0;
    rx_valid_in = 1'b0;
  endtask

  task automatic collect_tx(input int stall);
    logic       prev_v, prev_r;
    logic [7:0] prev_d;
    bit         rdy;
    txq.delete();
    any_req = 0;
    prev_v  = 1'b0;
    prev_r  = 1'b0;
    prev_d  = 8'h00;
    for (int c = 0; c < 200; c++) begin
      if (read_out || write_out) any_req++;
      if (prev_v && !prev_r && (!tx_valid_out || tx_data_out !== prev_d)) unstable++;
      if (!tx_valid_out && (txq.size() > 0 || c >= 20)) break;
      rdy         = (c < stall) ? 1'b0 : ($urandom_range(0, 3) != 0);
      tx_ready_in = rdy;
      if (tx_valid_out && rdy) txq.push_back(tx_data_out);
      prev_v = tx_valid_out;
      prev_r = rdy;
      prev_d = tx_data_out;
      @(negedge clk);
    end
    tx_ready_in = 1'b0;
  endtask

  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [3:0] mask,
                         input logic [3:0] mask_hi, input logic [31:0] wdata, input int ready_at,
                         input bit flt, input logic [31:0] rval, input bit stray, input int stall,
                         input string tag);
    bit         completes;
    int         exp_cycles;
    logic [7:0] stat;
    logic [7:0] expq[$];
    cmdq.delete();
    cmdq.push_back(wr ? 8'h02 : 8'h01);
    for (int i = 0; i < 4; i++) cmdq.push_back(addr[8*i +: 8]);
    if (wr) begin
      cmdq.push_back({mask_hi, mask});
      for (int i = 0; i < 4; i++) cmdq.push_back(wdata[8*i +: 8]);
    end
    send_cmd();
    run_bus(ready_at, flt, rval, stray);
    collect_tx(stall);

    completes  = (ready_at >= 1) && (ready_at <= TMO);
    exp_cycles = completes ? ready_at : TMO;
    stat       = !completes ? 8'h02 : (flt ? 8'h01 : 8'h00);
    expq.push_back(stat);
    if (!wr && stat == 8'h00)
      for (int i = 0; i < 4; i++) expq.push_back(rval[8*i +: 8]);

    chk({tag, ".req_cycles"}, req_cycles, exp_cycles);
    chk({tag, ".rd_wr"}, {seen_rd, seen_wr}, {!wr, wr});
    chk({tag, ".addr"}, seen_addr, addr);
    chk({tag, ".mask"}, seen_mask, wr ? mask : 4'b0000);
    if (wr) chk({tag, ".wvalue"}, seen_val, wdata);
    chk({tag, ".stable"}, unstable, 0);
    chk({tag, ".tx_len"}, txq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < txq.size(); i++)
      chk($sformatf("%s.tx%0d", tag, i), txq[i], expq[i]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    int          rat;
    reset = 1'b1; rx_data_in = 8'h00; rx_valid_in = 1'b0; tx_ready_in = 1'b0;
    read_value_in = 32'h0; ready_in = 1'b0; fault_in = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst.ctrl", {read_out, write_out, tx_valid_out, write_mask_out, tx_data_out}, 0);
    chk("rst.addr", address_out, 0);
    chk("rst.wvalue", write_value_out, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle.ctrl", {read_out, write_out, tx_valid_out}, 0);

    run_txn(0, 32'h0001_0000, 4'h0, 4'h0, 32'h0, 3, 0, 32'h0000_00A5, 0, 0, "read");
    run_txn(1, 32'h0001_000C, 4'h3, 4'h0, 32'hDEAD_BEEF, 1, 0, 32'h0, 0, 0, "write");
    run_txn(0, 32'h0400_0000, 4'h0, 4'h0, 32'h0, 1, 1, $urandom, 0, 0, "fault");
    run_txn(0, $urandom, 4'h0, 4'h0, 32'h0, 0, 0, 32'h0, 0, 0, "timeout");
    run_txn(0, $urandom, 4'h0, 4'h0, 32'h0, TMO, 0, 32'h1234_5678, 0, 0, "last_cycle_ok");
    run_txn(1, $urandom, 4'h9, 4'hF, $urandom, TMO + 1, 0, 32'h0, 0, 0, "write_timeout");

    cmdq.delete();
    cmdq.push_back(8'h7F);
    send_cmd();
    unstable = 0;
    collect_tx(10);
    chk("badcmd.tx_len", txq.size(), 1);
    if (txq.size() > 0) chk("badcmd.tx0", txq[0], 8'hFF);
    chk("badcmd.no_bus", any_req, 0);
    chk("badcmd.hold", unstable, 0);

    run_txn(0, $urandom, 4'h0, 4'h0, 32'h0, 2, 0, 32'hCAFE_F00D, 0, 10, "stall");
    run_txn(1, $urandom, 4'h5, 4'hA, $urandom, 4, 0, 32'h0, 1, 0, "stray_wr");
    run_txn(0, $urandom, 4'h0, 4'h0, 32'h0, 5, 0, $urandom, 1, 0, "stray_rd");

    cmdq.delete();
    cmdq = '{8'h01, 8'h10, 8'h20, 8'h30, 8'h40};
    send_cmd();
    chk("midrst.req_up", read_out, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst.req_drop", {read_out, write_out}, 0);
    reset         = 1'b0;
    ready_in      = 1'b1;
    read_value_in = 32'h5555_AAAA;
    @(negedge clk);
    ready_in = 1'b0;
    collect_tx(0);
    chk("midrst.no_tx", txq.size(), 0);
    chk("midrst.no_bus", any_req, 0);
    run_txn(0, 32'h8000_0004, 4'h0, 4'h0, 32'h0, 2, 0, 32'h0BAD_F00D, 0, 0, "post_rst");

    for (int n = 0; n < 16; n++) begin
      ra  = $urandom;
      rat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      run_txn(1'($urandom_range(0, 1)), ra, 4'($urandom), 4'($urandom), $urandom, rat,
              ($urandom_range(0, 3) == 0), $urandom, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
